bfp_conv_engine: RTL and testbench

Pipelined, parametrised block-floating-point convolution engine: one KERNEL_SIZE×KERNEL_SIZE window of half-precision-style pixels times kernel weights per beat, with per-window BFP normalisation, signed multiply and adder tree. Partial sums accumulate across input channels with cross-channel exponent alignment. Valid/ready handshakes on both sides allow back-to-back streaming of windows and channels. Sits between the window/line-buffer fetch and the output re-normaliser in the conv datapath.

---
 rtl/bfp_conv_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_bfp_conv_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_conv_engine.sv
// Block-floating-point KxK convolution engine: per-window exponent alignment, signed adder tree,
// cross-channel accumulation with exponent alignment. Define BFP_CONV_SAT_EN to saturate on overflow.
module bfp_conv_engine #(
  parameter int KERNEL_SIZE = 3,
  parameter int EXP_SIZE    = 5,
  parameter int MANT_SIZE   = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_W       = 32,
  parameter int CNT_W       = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_first,
  input  logic                                       in_last,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] img_i,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] ker_i,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_sign,
  output logic [ACC_W-1:0]                           out_mag,
  output logic [EXP_SIZE:0]                          out_exp,
  output logic [CNT_W-1:0]                           out_chans,
  output logic                                       out_ovf
);
  localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int VEC_W  = TAPS * DATA_WIDTH;
  localparam int SIG_W  = MANT_SIZE + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int SUM_W  = PROD_W + $clog2(TAPS) + 1;
  localparam int E_W    = EXP_SIZE + 1;

  // Handshake: a beat transfers on a clock edge where in_valid && in_ready, a result transfers
  // where out_valid && out_ready; the whole pipe advances only while the output slot can drain.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  function automatic logic [EXP_SIZE-1:0] f_exp(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-2:MANT_SIZE];
  endfunction

  function automatic logic [SIG_W-1:0] f_align(input logic [DATA_WIDTH-1:0] x,
                                               input logic [EXP_SIZE-1:0]   mx);
    logic [EXP_SIZE-1:0] sh;
    logic [SIG_W-1:0]    sig;
    sh  = mx - f_exp(x);
    sig = {(f_exp(x) != '0), x[MANT_SIZE-1:0]};
    if (int'(sh) >= SIG_W) return '0;
    return sig >> sh;
  endfunction

  function automatic logic signed [ACC_W-1:0] f_ashr(input logic signed [ACC_W-1:0] x,
                                                     input logic [E_W-1:0]          sh);
    if (int'(sh) >= ACC_W) return {ACC_W{x[ACC_W-1]}};
    return x >>> sh;
  endfunction

  // S1: input capture
  logic             v1_q, first1_q, last1_q;
  logic [VEC_W-1:0] img1_q, ker1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      img1_q   <= '0;
      ker1_q   <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        first1_q <= in_first;
        last1_q  <= in_last;
        img1_q   <= img_i;
        ker1_q   <= ker_i;
      end
    end
  end

  // S2: block normalisation and per-tap unsigned products
  logic [EXP_SIZE-1:0] max_i, max_k;
  logic [PROD_W-1:0]   prod_d [TAPS];
  logic [TAPS-1:0]     psgn_d;
  logic [E_W-1:0]      e2_d;

  always_comb begin
    max_i  = '0;
    max_k  = '0;
    psgn_d = '0;
    for (int t = 0; t < TAPS; t++) begin
      if (f_exp(img1_q[t*DATA_WIDTH +: DATA_WIDTH]) > max_i) max_i = f_exp(img1_q[t*DATA_WIDTH +: DATA_WIDTH]);
      if (f_exp(ker1_q[t*DATA_WIDTH +: DATA_WIDTH]) > max_k) max_k = f_exp(ker1_q[t*DATA_WIDTH +: DATA_WIDTH]);
    end
    for (int t = 0; t < TAPS; t++) begin
      prod_d[t] = PROD_W'(f_align(img1_q[t*DATA_WIDTH +: DATA_WIDTH], max_i)) *
                  PROD_W'(f_align(ker1_q[t*DATA_WIDTH +: DATA_WIDTH], max_k));
      psgn_d[t] = img1_q[t*DATA_WIDTH + DATA_WIDTH - 1] ^ ker1_q[t*DATA_WIDTH + DATA_WIDTH - 1];
    end
    e2_d = E_W'(max_i) + E_W'(max_k);
  end

  logic              v2_q, first2_q, last2_q;
  logic [PROD_W-1:0] prod_q [TAPS];
  logic [TAPS-1:0]   psgn_q;
  logic [E_W-1:0]    e2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      psgn_q   <= '0;
      e2_q     <= '0;
      for (int t = 0; t < TAPS; t++) prod_q[t] <= '0;
    end else if (en) begin
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      psgn_q   <= psgn_d;
      e2_q     <= e2_d;
      for (int t = 0; t < TAPS; t++) prod_q[t] <= prod_d[t];
    end
  end

  // S3: signed adder tree, wide enough that no tap sum can overflow
  logic signed [SUM_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int t = 0; t < TAPS; t++) begin
      if (psgn_q[t]) sum_d = sum_d - SUM_W'(prod_q[t]);
      else           sum_d = sum_d + SUM_W'(prod_q[t]);
    end
  end

  logic                    v3_q, first3_q, last3_q;
  logic signed [SUM_W-1:0] part_q;
  logic [E_W-1:0]          e3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3_q     <= 1'b0;
      first3_q <= 1'b0;
      last3_q  <= 1'b0;
      part_q   <= '0;
      e3_q     <= '0;
    end else if (en) begin
      v3_q     <= v2_q;
      first3_q <= first2_q;
      last3_q  <= last2_q;
      part_q   <= sum_d;
      e3_q     <= e2_q;
    end
  end

  // S4: channel accumulator; the operand with the smaller exponent is shifted down
  logic signed [ACC_W-1:0] acc_q, acc_d, part_ext, a_al, b_al, sum_w;
  logic [E_W-1:0]          acc_exp_q, acc_exp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d, add_ovf, done4_q;

  always_comb begin
    part_ext = ACC_W'(part_q);
    if (e3_q > acc_exp_q) begin
      a_al      = f_ashr(acc_q, e3_q - acc_exp_q);
      b_al      = part_ext;
      acc_exp_d = e3_q;
    end else begin
      a_al      = acc_q;
      b_al      = f_ashr(part_ext, acc_exp_q - e3_q);
      acc_exp_d = acc_exp_q;
    end
    sum_w   = a_al + b_al;
    add_ovf = (a_al[ACC_W-1] == b_al[ACC_W-1]) && (sum_w[ACC_W-1] != a_al[ACC_W-1]);
`ifdef BFP_CONV_SAT_EN
    if (add_ovf) acc_d = a_al[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else         acc_d = sum_w;
`else
    acc_d = sum_w;
`endif
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_d = ovf_q | add_ovf;
    if (first3_q) begin
      acc_d     = part_ext;
      acc_exp_d = e3_q;
      cnt_d     = CNT_W'(1);
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      acc_exp_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      done4_q   <= 1'b0;
    end else if (en) begin
      done4_q <= v3_q && last3_q;
      if (v3_q) begin
        acc_q     <= acc_d;
        acc_exp_q <= acc_exp_d;
        cnt_q     <= cnt_d;
        ovf_q     <= ovf_d;
      end
    end
  end

  // Output slot: loaded from the accumulator the cycle after a group's last beat lands
  logic             out_valid_q, out_sign_q, out_ovf_q;
  logic [ACC_W-1:0] out_mag_q, mag_d;
  logic [E_W-1:0]   out_exp_q;
  logic [CNT_W-1:0] out_chans_q;

  assign mag_d = acc_q[ACC_W-1] ? $unsigned(-acc_q) : $unsigned(acc_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= '0;
      out_exp_q   <= '0;
      out_chans_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= done4_q;
      if (done4_q) begin
        out_sign_q  <= acc_q[ACC_W-1];
        out_mag_q   <= mag_d;
        out_exp_q   <= acc_exp_q;
        out_chans_q <= cnt_q;
        out_ovf_q   <= ovf_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;
  assign out_exp   = out_exp_q;
  assign out_chans = out_chans_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_bfp_conv_engine.sv
// Directed bench for bfp_conv_engine: vector table, stall sequence, 28-bit overflow group, mid-group reset.
module tb_bfp_conv_engine;
  localparam int VW = 144;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [VW-1:0] img_i = '0, ker_i = '0;
  logic          in_ready, out_valid, out_sign, out_ovf;
  logic [31:0]   out_mag;
  logic [5:0]    out_exp;
  logic [7:0]    out_chans;
  logic          in_ready1, out_valid1, out_sign1, out_ovf1;
  logic [27:0]   out_mag1;
  logic [5:0]    out_exp1;
  logic [7:0]    out_chans1;

  bfp_conv_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .img_i(img_i), .ker_i(ker_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_exp(out_exp), .out_chans(out_chans), .out_ovf(out_ovf)
  );

  bfp_conv_engine #(.ACC_W(28)) dut28 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_first(in_first),
    .in_last(in_last), .img_i(img_i), .ker_i(ker_i), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sign(out_sign1), .out_mag(out_mag1), .out_exp(out_exp1), .out_chans(out_chans1), .out_ovf(out_ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] img;
    logic [VW-1:0] ker;
    logic          first;
    logic          last;
    logic [47:0]   res;   // {sign, mag[31:0], exp[5:0], chans[7:0], ovf}
  } vec_t;

  vec_t        vecs [12];
  logic [47:0] exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [VW-1:0] mk(input logic [15:0] t0, input logic [15:0] rest);
    logic [VW-1:0] v;
    for (int t = 0; t < 9; t++) v[t*16 +: 16] = (t == 0) ? t0 : rest;
    return v;
  endfunction

  function automatic vec_t vrec(input logic [15:0] i0, input logic [15:0] ir, input logic [15:0] kr,
                                input logic f, input logic l, input logic s, input logic [31:0] m,
                                input logic [5:0] e, input logic [7:0] c);
    vec_t v;
    v.img = mk(i0, ir);
    v.ker = mk(kr, kr);
    v.first = f;
    v.last = l;
    v.res = {s, m, e, c, 1'b0};
    return v;
  endfunction

  task automatic send(input logic [VW-1:0] img, input logic [VW-1:0] ker, input logic f, input logic l);
    int k;
    @(negedge clk);
    img_i = img; ker_i = ker; in_first = f; in_last = l; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", k);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    if (v.last) exp_q.push_back(v.res);
    send(v.img, v.ker, v.first, v.last);
  endtask

  // Scoreboard: a handshake seen at the negedge completes on the next posedge
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: got mag 0x%0h, expected no result", out_mag);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("out_sign",  64'(out_sign),  64'(e[47]));
        chk("out_mag",   64'(out_mag),   64'(e[46:15]));
        chk("out_exp",   64'(out_exp),   64'(e[14:9]));
        chk("out_chans", 64'(out_chans), 64'(e[8:1]));
        chk("out_ovf",   64'(out_ovf),   64'(e[0]));
      end
    end
  end

  initial begin
    logic [47:0] snap;
    int k;
    int stall_idx [7];

    vecs[0]  = vrec(16'h3C00, 16'h3C00, 16'h3C00, 1, 1, 0, 32'h0090_0000, 30, 1);
    vecs[1]  = vrec(16'h4000, 16'h3C00, 16'h3C00, 1, 1, 0, 32'h0050_0000, 31, 1);
    vecs[2]  = vrec(16'h3C00, 16'h3C00, 16'hBC00, 1, 1, 1, 32'h0090_0000, 30, 1);
    vecs[3]  = vrec(16'h3C00, 16'h3C00, 16'h3C00, 1, 0, 0, 32'h0, 0, 0);
    vecs[4]  = vrec(16'h4000, 16'h4000, 16'h3C00, 0, 1, 0, 32'h00D8_0000, 31, 2);
    vecs[5]  = vrec(16'h3C00, 16'h3C00, 16'h3C00, 1, 0, 0, 32'h0, 0, 0);
    vecs[6]  = vrec(16'h3C00, 16'h3C00, 16'h3C00, 0, 1, 0, 32'h0120_0000, 30, 2);
    vecs[7]  = vrec(16'h0000, 16'h0000, 16'h3C00, 1, 1, 0, 32'h0, 15, 1);
    vecs[8]  = vrec(16'h7C00, 16'h3C00, 16'h3C00, 1, 1, 0, 32'h0010_0000, 46, 1);
    vecs[9]  = vrec(16'hBC00, 16'h3C00, 16'h3C00, 1, 1, 0, 32'h0070_0000, 30, 1);
    vecs[10] = vrec(16'h4000, 16'h4000, 16'h3C00, 1, 0, 0, 32'h0, 0, 0);
    vecs[11] = vrec(16'hBC00, 16'hBC00, 16'h3C00, 0, 1, 0, 32'h0048_0000, 31, 2);
    stall_idx = '{0, 1, 2, 7, 8, 9, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_fields", {out_sign, out_mag, out_exp, out_chans, out_ovf}, 64'd0);
    rst = 1'b1;

    // Vector table; the first entry also checks latency
    for (int i = 0; i < 12; i++) begin
      send_vec(vecs[i]);
      if (i == 0) begin
        for (int c = 1; c <= 5; c++) begin
          @(negedge clk);
          chk($sformatf("latency_c%0d", c), 64'(out_valid), 64'(c == 5));
        end
      end
    end

    // Back-to-back groups under a 3-cycle output stall
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 7; i++) send_vec(vecs[stall_idx[i]]);
      end
      begin
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 30) begin
          @(negedge clk);
          k++;
        end
        chk("stall_out_valid_seen", 64'(out_valid), 64'd1);
        snap = {out_sign, out_mag, out_exp, out_chans, out_ovf};
        chk("stall_first_mag", 64'(out_mag), 64'h0090_0000);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_frozen", 64'({out_sign, out_mag, out_exp, out_chans, out_ovf}), 64'(snap));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // 16-channel group: fits in 32 bits, overflows the 28-bit accumulator
    for (int b = 0; b < 16; b++) begin
      if (b == 15) exp_q.push_back({1'b0, 32'h0900_0000, 6'd30, 8'd16, 1'b0});
      send(mk(16'h3C00, 16'h3C00), mk(16'h3C00, 16'h3C00), b == 0, b == 15);
    end
    k = 0;
    while (!out_valid1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("acc28_valid", 64'(out_valid1), 64'd1);
`ifdef BFP_CONV_SAT_EN
    chk("acc28_sign", 64'(out_sign1), 64'd0);
    chk("acc28_mag",  64'(out_mag1),  64'h7FF_FFFF);
`else
    chk("acc28_sign", 64'(out_sign1), 64'd1);
    chk("acc28_mag",  64'(out_mag1),  64'h700_0000);
`endif
    chk("acc28_ovf",   64'(out_ovf1),   64'd1);
    chk("acc28_chans", 64'(out_chans1), 64'd16);
    chk("acc28_exp",   64'(out_exp1),   64'd30);

    // Reset with a complete group in flight: nothing may come out
    repeat (4) @(posedge clk);
    send(mk(16'h3C00, 16'h3C00), mk(16'h3C00, 16'h3C00), 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Non-first beat after reset accumulates onto a zero accumulator
    send_vec(vrec(16'h3C00, 16'h3C00, 16'h3C00, 0, 1, 0, 32'h0090_0000, 30, 1));

    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
